// File: rtl/dht11_responder.sv
// dht11_responder: device-side DHT11 emulator answering a host start pulse with preamble + 40-bit frame.
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   dado                open-drain data line (driven 0 or Z only)
//   humid_int/humid_dec humidity bytes, temp_int/temp_dec temperature bytes
//   inject_err          only with CHECKSUM_ERR_INJ_EN: invert the latched checksum
//   busy                high from RESP_WAIT entry through END_LOW exit
//   frame_done          one-cycle pulse at frame completion
// Optional feature macro: CHECKSUM_ERR_INJ_EN
module dht11_responder #(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int START_MIN_US = 18000,
    parameter int RESP_WAIT_US = 30
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        dado,
    input  logic [7:0] humid_int,
    input  logic [7:0] humid_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
`ifdef CHECKSUM_ERR_INJ_EN
    input  logic       inject_err,
`endif
    output logic       busy,
    output logic       frame_done
);
    localparam int TPU = CLK_FREQ_HZ / 1_000_000;
    localparam int PW = (TPU > 1) ? $clog2(TPU) : 1;
    localparam logic [PW-1:0] TICK_AT = PW'(TPU - 1);
    // The IDLE cycle that first saw the line low is credited to the host low time.
    localparam logic [PW-1:0] PRESC_START = (TPU > 1) ? PW'(1) : '0;
    localparam logic [14:0] CNT_START = (TPU > 1) ? 15'd0 : 15'd1;

    typedef enum logic [2:0] {IDLE, HOST_LOW, RESP_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW} state_t;

    state_t state;
    logic syncA, lineS, drive;
    logic [PW-1:0] presc;
    logic [14:0] usCnt, stateLen;
    logic [39:0] shiftReg;
    logic [5:0] bitCnt;
    logic [7:0] checksum;
    logic usTick, stateDone, leaving;

    assign dado = drive ? 1'b0 : 1'bz;

    always_comb begin
        checksum = humid_int + humid_dec + temp_int + temp_dec;
`ifdef CHECKSUM_ERR_INJ_EN
        checksum = checksum ^ {8{inject_err}};
`endif
        usTick = presc == TICK_AT;
        stateLen = (state == RESP_WAIT) ? 15'(RESP_WAIT_US) :
                   (state == RESP_LOW || state == RESP_HIGH) ? 15'd80 :
                   (state == BIT_HIGH) ? (shiftReg[39] ? 15'd70 : 15'd26) : 15'd50;
        stateDone = usTick && usCnt == stateLen - 15'd1 && state != IDLE && state != HOST_LOW;
        leaving = stateDone || (state == IDLE && !lineS) || (state == HOST_LOW && lineS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            syncA      <= 1'b1;
            lineS      <= 1'b1;
            drive      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            presc      <= '0;
            usCnt      <= '0;
            shiftReg   <= '0;
            bitCnt     <= '0;
        end else begin
            syncA      <= dado;
            lineS      <= syncA;
            frame_done <= 1'b0;
            // Prescaler and µs counter restart on every state change.
            if (leaving) begin
                presc <= (state == IDLE) ? PRESC_START : '0;
                usCnt <= (state == IDLE) ? CNT_START : '0;
            end else begin
                presc <= usTick ? '0 : presc + 1'b1;
                if (usTick && usCnt != 15'h7FFF)
                    usCnt <= usCnt + 1'b1;
            end
            case (state)
                IDLE: if (!lineS) state <= HOST_LOW;
                HOST_LOW: if (lineS) begin
                    if (usCnt >= 15'(START_MIN_US)) begin
                        state    <= RESP_WAIT;
                        busy     <= 1'b1;
                        shiftReg <= {humid_int, humid_dec, temp_int, temp_dec, checksum};
                        bitCnt   <= 6'd40;
                    end else
                        state <= IDLE;
                end
                RESP_WAIT: if (stateDone) begin
                    state <= RESP_LOW;
                    drive <= 1'b1;
                end
                RESP_LOW: if (stateDone) begin
                    state <= RESP_HIGH;
                    drive <= 1'b0;
                end
                RESP_HIGH: if (stateDone) begin
                    state <= BIT_LOW;
                    drive <= 1'b1;
                end
                BIT_LOW: if (stateDone) begin
                    state <= BIT_HIGH;
                    drive <= 1'b0;
                end
                BIT_HIGH: if (stateDone) begin
                    shiftReg <= shiftReg << 1;
                    bitCnt   <= bitCnt - 1'b1;
                    state    <= (bitCnt == 6'd1) ? END_LOW : BIT_LOW;
                    drive    <= 1'b1;
                end
                END_LOW: if (stateDone) begin
                    state      <= IDLE;
                    drive      <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: vector table of start requests, scoreboard-checked frame decoding from the line.
module tb_dht11_responder;
    logic clk = 1'b0, rst = 1'b1, hostDrive = 1'b0, injectErr = 1'b0;
    logic [7:0] humidInt = '0, humidDec = '0, tempInt = '0, tempDec = '0;
    logic busy, frameDone, dutLow;
    wire dadoBus;

    pullup (dadoBus);
    assign dadoBus = hostDrive ? 1'b0 : 1'bz;
    // Low caused by the responder; the host only interferes while the responder is released.
    assign dutLow = !hostDrive && (dadoBus === 1'b0);

    always #5 clk = ~clk;

    dht11_responder #(.CLK_FREQ_HZ(1_000_000), .START_MIN_US(18000), .RESP_WAIT_US(30)) dut (
        .clk(clk),
        .reset(rst),
        .dado(dadoBus),
        .humid_int(humidInt),
        .humid_dec(humidDec),
        .temp_int(tempInt),
        .temp_dec(tempDec),
`ifdef CHECKSUM_ERR_INJ_EN
        .inject_err(injectErr),
`endif
        .busy(busy),
        .frame_done(frameDone)
    );

    typedef struct {
        int hold;
        logic [31:0] bytes;
        bit accept;
        int resetBit;
        bit interfere;
    } vec_t;

    vec_t vecs[4];
    logic [39:0] expQ[$];
    int nChecks = 0, nPass = 0, doneCnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act === req) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic logic [39:0] frameOf(input logic [31:0] b, input logic inj);
        logic [7:0] s;
        s = b[31:24] + b[23:16] + b[15:8] + b[7:0];
        return {b, s ^ {8{inj}}};
    endfunction

    function automatic int bitW(input logic b);
        return b ? 70 : 26;
    endfunction

    function automatic int frameLen(input logic [39:0] f);
        int s;
        s = 160 + 50;
        for (int i = 0; i < 40; i++) s += 50 + bitW(f[i]);
        return s;
    endfunction

    function automatic int resetAt(input logic [39:0] f, input int n);
        int s;
        s = 160 + 20;
        for (int i = 0; i < n; i++) s += 50 + bitW(f[39-i]);
        return s;
    endfunction

    initial forever begin
        @(negedge clk);
        if (frameDone) doneCnt++;
    end

    // Line monitor: decodes run lengths of the responder's low/high phases into a frame.
    initial begin
        logic prevLow;
        int runLen, idx;
        logic [39:0] cur, got;
        prevLow = 1'b0; runLen = 0; idx = 0; cur = '0; got = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevLow = 1'b0; runLen = 0; idx = 0;
            end else if (dutLow == prevLow) runLen++;
            else begin
                if (prevLow) begin
                    if (idx == 0) begin
                        check("frame expected", 64'(expQ.size() != 0), 1);
                        if (expQ.size() != 0) cur = expQ[0];
                        check("resp low", runLen, 80);
                        check("busy in frame", busy, 1);
                    end else if (idx <= 40) begin
                        check("bit low", runLen, 50);
                        check("busy in frame", busy, 1);
                    end else begin
                        check("end low", runLen, 50);
                        check("frame_done at end", frameDone, 1);
                        check("busy after end", busy, 0);
                        if (expQ.size() != 0) void'(expQ.pop_front());
                        check("frame", got, cur);
                    end
                    idx = (idx == 41) ? 0 : idx + 1;
                end else if (idx == 1) check("resp high", runLen, 80);
                else if (idx >= 2) begin
                    got[41-idx] = runLen > 48;
                    check("bit high", runLen, bitW(cur[41-idx]));
                end
                prevLow = dutLow;
                runLen = 1;
            end
        end
    end

    initial begin
        int lat, cnt, rAt, expDone;
        logic [39:0] f;
        bit found, sawLow, sawBusy;
        vecs[0] = '{18000, 32'h37001900, 1'b1, -1, 1'b0};
        vecs[1] = '{17999, 32'h37001900, 1'b0, -1, 1'b0};
        vecs[2] = '{18000, 32'h12345678, 1'b1, 12, 1'b0};
        vecs[3] = '{18000, 32'hFFFFFF03, 1'b1, -1, 1'b1};
        expDone = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset dado released", 64'(dadoBus === 1'b1), 1);
        check("reset busy", busy, 0);
        check("reset frame_done", frameDone, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        for (int v = 0; v < 4; v++) begin
            {humidInt, humidDec, tempInt, tempDec} = vecs[v].bytes;
`ifdef CHECKSUM_ERR_INJ_EN
            injectErr = (v == 0);
`endif
            f = frameOf(vecs[v].bytes, injectErr);
            @(posedge clk);
            #1 hostDrive = 1'b1;
            repeat (vecs[v].hold) @(posedge clk);
            #1 hostDrive = 1'b0;
            if (!vecs[v].accept) begin
                sawLow = 1'b0; sawBusy = 1'b0;
                repeat (200) begin
                    @(negedge clk);
                    sawLow |= dutLow;
                    sawBusy |= busy;
                end
                check("short pulse drive", sawLow, 0);
                check("short pulse busy", sawBusy, 0);
                check("short pulse frame_done count", doneCnt, expDone);
                continue;
            end
            expQ.push_back(f);
            found = 1'b0; lat = 0;
            for (int k = 1; k <= 100 && !found; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (dutLow) begin found = 1'b1; lat = k; end
            end
            check("release to first drive", lat, 33);
            if (!found) begin expQ.delete(); continue; end
            rAt = (vecs[v].resetBit >= 0) ? resetAt(f, vecs[v].resetBit) : -1;
            cnt = 0; found = 1'b0;
            while (cnt < 8000 && !found) begin
                @(negedge clk);
                cnt++;
                if (vecs[v].interfere && cnt == 215) begin
                    hostDrive = 1'b1;
                    {humidInt, humidDec, tempInt, tempDec} = 32'h0;
                end
                if (vecs[v].interfere && cnt == 225) hostDrive = 1'b0;
                if (cnt == rAt) begin
                    #2 rst = 1'b1;
                    #1;
                    check("mid-frame reset releases dado", 64'(dadoBus === 1'b1), 1);
                    check("mid-frame reset busy", busy, 0);
                    found = 1'b1;
                end else if (frameDone) found = 1'b1;
            end
            if (rst) begin
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                expQ.delete();
                repeat (5) @(posedge clk);
                check("frame_done count after reset", doneCnt, expDone);
                continue;
            end
            check("frame length", cnt, frameLen(f));
            expDone++;
            repeat (3) @(negedge clk);
            check("frame_done count", doneCnt, expDone);
            repeat (20) @(posedge clk);
        end
        check("scoreboard drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
